smps_sequencer: RTL and testbench
=================================

SMPS_SEQUENCER -- requirements
Module: smps_sequencer

Interface
REQ-001 SHALL use one clock, i_clk; reset is synchronous and active-high, port name reset.
REQ-002 SHALL expose the following parameters:
- SS_TIMEOUT, 4096: max cycles allowed in SOFT_START before a fault.
- PG_DELAY, 16: cycles of clean RUN before o_power_good asserts.
- FLT_FILTER, 4: consecutive cycles a fault input must be high to count.
- HICCUP_CYCLES, 1000: off-time between retries.
- MAX_RETRIES, 3: consecutive faults tolerated before latch-off.
- DUTY_MAX, 230: upper clamp on o_duty.
REQ-003 SHALL have the following ports:
- i_clk  in  1  clock
- reset  in  1  sync active-high reset
- i_enable  in  1  converter enable request
- i_ss_done  in  1  soft-start ramp complete
- i_ss_duty  in  8  soft-start duty select
- i_reg_duty  in  8  regulation-loop duty
- i_ocp  in  1  raw overcurrent flag
- i_ovp  in  1  raw overvoltage flag
- o_ss_enable  out  1  enable to soft-start block
- o_pwm_enable  out  1  PWM stage enable
- o_duty  out  8  duty to PWM
- o_power_good  out  1  output in regulation
- o_fault  out  1  fault present (FAULT/HICCUP/LATCHED)
- o_latched  out  1  latch-off active
- o_state  out  3  current state code

Function
REQ-004 SHALL implement the states OFF=0, SOFT_START=1, RUN=2, FAULT=3, HICCUP=4 and LATCHED=5.
REQ-005 OFF: on i_enable=1, go to SOFT_START next cycle; clear the timer.
REQ-006 SOFT_START: o_ss_enable=1, o_pwm_enable=1, o_duty=min(i_ss_duty,DUTY_MAX); on i_ss_done=1, go to RUN; if the timer reaches SS_TIMEOUT-1 without done, go to FAULT.
REQ-007 RUN: o_ss_enable=0, o_pwm_enable=1, o_duty=min(i_reg_duty,DUTY_MAX); o_power_good=1 after PG_DELAY consecutive RUN cycles, and the consecutive-fault count then clears to 0.
REQ-008 Filtered fault = i_ocp or i_ovp high for FLT_FILTER consecutive cycles; the per-input counters saturate and clear on any low cycle.
REQ-009 A filtered fault in SOFT_START or RUN SHALL go to FAULT next cycle, with o_pwm_enable=0, o_duty=0 and o_power_good=0 on that same registered edge.
REQ-010 FAULT (one cycle): increment the fault count; if the count reaches MAX_RETRIES, go to LATCHED, else go to HICCUP with the timer cleared.
REQ-011 HICCUP: outputs off; after HICCUP_CYCLES cycles go to SOFT_START if i_enable=1, else go to OFF.
REQ-012 LATCHED: outputs off, o_latched=1; exit to OFF only when i_enable=0, which also clears the fault count.
REQ-013 i_enable=0 in SOFT_START or RUN SHALL go to OFF next cycle with outputs off; the fault count is retained.
REQ-014 Fault beats i_ss_done when both arrive in the same cycle.
REQ-015 Fault beats i_enable deassertion when both arrive in the same cycle.
REQ-016 All outputs SHALL be registered; latency from input to o_duty is 1 cycle; the duty clamp is an unsigned 8-bit compare.
REQ-017 The timer SHALL be a single shared 16-bit saturating counter, cleared on every state entry.
REQ-018 The fault counter SHALL be 2 bits minimum, sized by $clog2(MAX_RETRIES+1).

Reset
REQ-019 On reset: state=OFF; all outputs 0; timer, filter counters and fault count all 0.
REQ-020 Reset asserted mid-operation SHALL force OFF on the next edge regardless of state, and override i_enable in the same cycle.

Structure
REQ-021 State codes, the default parameter values and the duty width (8) SHALL live in shared package smps_pkg.
REQ-022 The consecutive-cycle debounce SHALL be sub-module fault_filter, instantiated once each for OCP and OVP.

Verification
REQ-023 Normal start: reset, i_enable=1, i_ss_done at cycle 50 -> o_state 1 then 2, o_ss_enable drops at cycle 51, o_power_good=1 at cycle 67.
REQ-024 Clamp: i_reg_duty=250 in RUN -> o_duty=230; i_reg_duty=100 -> o_duty=100 one cycle later.
REQ-025 OCP glitch vs fault: i_ocp high 3 cycles -> no fault; high 4 cycles -> FAULT, o_pwm_enable=0, HICCUP for 1000 cycles, then SOFT_START.
REQ-026 Latch-off: persistent i_ocp -> three fault cycles -> LATCHED, o_latched=1; i_enable=0 -> OFF and count 0; i_enable=1 -> restart.
REQ-027 SS timeout: i_ss_done held 0 -> FAULT at cycle 4096 of SOFT_START.
REQ-028 Simultaneous events: i_ss_done and filtered OVP in the same cycle -> FAULT; reset during HICCUP -> OFF, all outputs 0 next edge.

Source files
------------

// File: rtl/smps_pkg.sv
// Shared definitions for the SMPS start-up / protection sequencer:
// state codes, default tuning values and the duty word width.
package smps_pkg;

  localparam int DUTY_W = 8;

  localparam int DEF_SS_TIMEOUT    = 4096;
  localparam int DEF_PG_DELAY      = 16;
  localparam int DEF_FLT_FILTER    = 4;
  localparam int DEF_HICCUP_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_DUTY_MAX      = 230;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_SOFT_START = 3'd1,
    ST_RUN        = 3'd2,
    ST_FAULT      = 3'd3,
    ST_HICCUP     = 3'd4,
    ST_LATCHED    = 3'd5
  } state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] max);
    return (duty > max) ? max : duty;
  endfunction

endpackage

// File: rtl/fault_filter.sv
// Consecutive-cycle debounce for a raw protection flag; the flag counts
// only on the cycle it has been high FILTER cycles in a row.
module fault_filter #(
  parameter int FILTER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] FULL = CW'(FILTER);
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= '0;
    else if (!raw)        cnt <= '0;
    else if (cnt != FULL) cnt <= cnt + 1'b1;
  end

  // the current high cycle completes the run, so react without an extra cycle
  assign filtered = raw && (cnt >= LAST);

endmodule

// File: rtl/smps_sequencer.sv
// SMPS power-up sequencer: soft-start, regulation, filtered OCP/OVP
// protection with hiccup retries and latch-off after repeated faults.
//
// state      | meaning
// OFF        | converter idle, waiting for enable
// SOFT_START | soft-start ramp running, timeout supervised
// RUN        | regulation loop drives duty, power-good after delay
// FAULT      | one-cycle fault bookkeeping
// HICCUP     | off-time before a retry
// LATCHED    | too many faults, held off until enable drops
module smps_sequencer
  import smps_pkg::*;
#(
  parameter int SS_TIMEOUT    = DEF_SS_TIMEOUT,
  parameter int PG_DELAY      = DEF_PG_DELAY,
  parameter int FLT_FILTER    = DEF_FLT_FILTER,
  parameter int HICCUP_CYCLES = DEF_HICCUP_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int DUTY_MAX      = DEF_DUTY_MAX
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic              i_enable,
  input  logic              i_ss_done,
  input  logic [DUTY_W-1:0] i_ss_duty,
  input  logic [DUTY_W-1:0] i_reg_duty,
  input  logic              i_ocp,
  input  logic              i_ovp,
  output logic              o_ss_enable,
  output logic              o_pwm_enable,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_power_good,
  output logic              o_fault,
  output logic              o_latched,
  output logic [2:0]        o_state
);

  localparam int TW  = 16;
  localparam int FCW = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0]     SS_LAST = TW'(SS_TIMEOUT - 1);
  localparam logic [TW-1:0]     HC_LAST = TW'(HICCUP_CYCLES - 1);
  localparam logic [TW-1:0]     PG_LAST = TW'(PG_DELAY - 1);
  localparam logic [FCW-1:0]    FC_MAX  = FCW'(MAX_RETRIES);
  localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(DUTY_MAX);

  state_t state, state_n;
  logic [TW-1:0]     timer;
  logic [FCW-1:0]    fault_cnt, fault_cnt_n;
  logic              ocp_flt, ovp_flt, flt;
  logic              ss_en_n, pwm_n, pg_n, fault_n, latched_n;
  logic [DUTY_W-1:0] duty_n;

  fault_filter #(.FILTER(FLT_FILTER)) u_ocp_filter (
    .clk(i_clk), .reset(reset), .raw(i_ocp), .filtered(ocp_flt)
  );
  fault_filter #(.FILTER(FLT_FILTER)) u_ovp_filter (
    .clk(i_clk), .reset(reset), .raw(i_ovp), .filtered(ovp_flt)
  );

  assign flt = ocp_flt || ovp_flt;

  always_comb begin
    state_n     = state;
    fault_cnt_n = fault_cnt;
    ss_en_n     = 1'b0;
    pwm_n       = 1'b0;
    duty_n      = '0;
    pg_n        = 1'b0;
    // a filtered fault outranks enable removal and ramp completion
    case (state)
      ST_OFF:        if (i_enable) state_n = ST_SOFT_START;
      ST_SOFT_START: begin
        if (flt)                  state_n = ST_FAULT;
        else if (!i_enable)       state_n = ST_OFF;
        else if (i_ss_done)       state_n = ST_RUN;
        else if (timer >= SS_LAST) state_n = ST_FAULT;
      end
      ST_RUN: begin
        if (flt)            state_n = ST_FAULT;
        else if (!i_enable) state_n = ST_OFF;
      end
      ST_FAULT: begin
        fault_cnt_n = (fault_cnt >= FC_MAX) ? fault_cnt : fault_cnt + 1'b1;
        state_n     = (fault_cnt_n >= FC_MAX) ? ST_LATCHED : ST_HICCUP;
      end
      ST_HICCUP:  if (timer >= HC_LAST) state_n = i_enable ? ST_SOFT_START : ST_OFF;
      ST_LATCHED: begin
        if (!i_enable) begin
          state_n     = ST_OFF;
          fault_cnt_n = '0;
        end
      end
      default:    state_n = ST_OFF;
    endcase

    case (state_n)
      ST_SOFT_START: begin
        ss_en_n = 1'b1;
        pwm_n   = 1'b1;
        duty_n  = clamp_duty(i_ss_duty, DMAX);
      end
      ST_RUN: begin
        pwm_n  = 1'b1;
        duty_n = clamp_duty(i_reg_duty, DMAX);
        pg_n   = (state == ST_RUN) && (timer >= PG_LAST);
      end
      default: ;
    endcase

    // a converter that reached regulation has proven itself; forget old faults
    if (pg_n) fault_cnt_n = '0;
    fault_n   = (state_n == ST_FAULT) || (state_n == ST_HICCUP) || (state_n == ST_LATCHED);
    latched_n = (state_n == ST_LATCHED);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state        <= ST_OFF;
      timer        <= '0;
      fault_cnt    <= '0;
      o_ss_enable  <= 1'b0;
      o_pwm_enable <= 1'b0;
      o_duty       <= '0;
      o_power_good <= 1'b0;
      o_fault      <= 1'b0;
      o_latched    <= 1'b0;
    end else begin
      state        <= state_n;
      fault_cnt    <= fault_cnt_n;
      if (state_n != state)  timer <= '0;
      else if (timer != '1)  timer <= timer + 1'b1;
      o_ss_enable  <= ss_en_n;
      o_pwm_enable <= pwm_n;
      o_duty       <= duty_n;
      o_power_good <= pg_n;
      o_fault      <= fault_n;
      o_latched    <= latched_n;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_smps_sequencer.sv
// Directed bench for smps_sequencer: a vector table for the short paths,
// hand-written sequences for timing, hiccup, latch-off and timeout.
module tb_smps_sequencer;

  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_enable = 1'b0, i_ss_done = 1'b0, i_ocp = 1'b0, i_ovp = 1'b0;
  logic [7:0] i_ss_duty = '0, i_reg_duty = '0;
  logic       o_ss_enable, o_pwm_enable, o_power_good, o_fault, o_latched;
  logic [7:0] o_duty;
  logic [2:0] o_state;

  int total = 0;
  int bad   = 0;

  smps_sequencer dut (
    .i_clk(i_clk), .reset(reset), .i_enable(i_enable), .i_ss_done(i_ss_done),
    .i_ss_duty(i_ss_duty), .i_reg_duty(i_reg_duty), .i_ocp(i_ocp), .i_ovp(i_ovp),
    .o_ss_enable(o_ss_enable), .o_pwm_enable(o_pwm_enable), .o_duty(o_duty),
    .o_power_good(o_power_good), .o_fault(o_fault), .o_latched(o_latched),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst, en, done;
    logic [7:0] ss_d, reg_d;
    logic       ocp, ovp;
    logic [2:0] st;
    logic       ss_en, pwm;
    logic [7:0] duty;
    logic       pg, flt, lat;
  } vec_t;

  vec_t tbl[0:20];

  function automatic logic [15:0] pk(input logic [2:0] st, input logic ss_en, input logic pwm,
                                     input logic [7:0] duty, input logic pg, input logic flt,
                                     input logic lat);
    return {st, ss_en, pwm, duty, pg, flt, lat};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_enable = 1'b0; i_ss_done = 1'b0; i_ocp = 1'b0; i_ovp = 1'b0;
    i_ss_duty = 8'd0; i_reg_duty = 8'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // returns number of faults entered before LATCHED shows up (bounded)
  task automatic count_faults_to_latch(output int faults);
    int n;
    faults = 0;
    n = 0;
    while (o_state != 3'd5 && n < 5000) begin
      tick();
      n++;
      if (o_state == 3'd3) faults++;
    end
  endtask

  initial begin
    int n;
    int f;

    //            rst  en   done ss_d   reg_d  ocp  ovp   st    ss_en pwm  duty    pg   flt  lat
    tbl[0]  = '{1'b1,1'b0,1'b0,8'd0,  8'd0,  1'b0,1'b0, 3'd0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,8'd0,  8'd0,  1'b0,1'b0, 3'd0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b0,8'd50, 8'd0,  1'b0,1'b0, 3'd1,1'b1,1'b1,8'd50, 1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,8'd240,8'd0,  1'b0,1'b0, 3'd1,1'b1,1'b1,8'd230,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b0,8'd230,8'd0,  1'b0,1'b0, 3'd1,1'b1,1'b1,8'd230,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'd231,8'd0,  1'b0,1'b0, 3'd1,1'b1,1'b1,8'd230,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,8'd10, 8'd250,1'b0,1'b0, 3'd2,1'b0,1'b1,8'd230,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,8'd10, 8'd100,1'b0,1'b0, 3'd2,1'b0,1'b1,8'd100,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,8'd10, 8'd0,  1'b1,1'b0, 3'd2,1'b0,1'b1,8'd0,  1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b0,8'd10, 8'd0,  1'b1,1'b0, 3'd2,1'b0,1'b1,8'd0,  1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,8'd10, 8'd0,  1'b1,1'b0, 3'd2,1'b0,1'b1,8'd0,  1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,8'd10, 8'd77, 1'b0,1'b0, 3'd2,1'b0,1'b1,8'd77, 1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,8'd10, 8'd77, 1'b0,1'b0, 3'd0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,8'd10, 8'd77, 1'b0,1'b0, 3'd0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b0, 3'd1,1'b1,1'b1,8'd5,  1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b1, 3'd1,1'b1,1'b1,8'd5,  1'b0,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b1, 3'd1,1'b1,1'b1,8'd5,  1'b0,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b1, 3'd1,1'b1,1'b1,8'd5,  1'b0,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b1,1'b1,8'd5,  8'd77, 1'b0,1'b1, 3'd3,1'b0,1'b0,8'd0,  1'b0,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b0, 3'd4,1'b0,1'b0,8'd0,  1'b0,1'b1,1'b0};
    tbl[20] = '{1'b1,1'b1,1'b0,8'd5,  8'd77, 1'b0,1'b0, 3'd0,1'b0,1'b0,8'd0,  1'b0,1'b0,1'b0};

    for (int i = 0; i <= 20; i++) begin
      reset = tbl[i].rst; i_enable = tbl[i].en; i_ss_done = tbl[i].done;
      i_ss_duty = tbl[i].ss_d; i_reg_duty = tbl[i].reg_d;
      i_ocp = tbl[i].ocp; i_ovp = tbl[i].ovp;
      tick();
      chk($sformatf("vec%0d", i),
          int'(pk(o_state, o_ss_enable, o_pwm_enable, o_duty, o_power_good, o_fault, o_latched)),
          int'(pk(tbl[i].st, tbl[i].ss_en, tbl[i].pwm, tbl[i].duty, tbl[i].pg, tbl[i].flt, tbl[i].lat)));
    end

    // normal start: done after 49 ramp cycles, power-good 16 RUN edges later
    do_reset();
    i_enable = 1'b1; i_ss_duty = 8'd20; i_reg_duty = 8'd120;
    for (int k = 0; k < 50; k++) tick();
    chk("ss_hold_state", o_state, 1);
    i_ss_done = 1'b1;
    tick();
    i_ss_done = 1'b0;
    chk("run_entry", int'({o_state, o_ss_enable, o_pwm_enable, o_duty}), int'({3'd2, 1'b0, 1'b1, 8'd120}));
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("pg_edge%0d", k), o_power_good, (k == 16) ? 1 : 0);
    end

    // four OCP cycles in RUN -> fault, 1000 hiccup cycles, retry
    i_ocp = 1'b1;
    tick(); tick(); tick();
    chk("ocp3_run", o_state, 2);
    tick();
    i_ocp = 1'b0;
    chk("ocp4_fault", int'({o_state, o_pwm_enable, o_duty, o_power_good, o_fault}),
        int'({3'd3, 1'b0, 8'd0, 1'b0, 1'b1}));
    tick();
    n = 0;
    while (o_state == 3'd4 && n < 1100) begin n++; tick(); end
    chk("hiccup_len", n, 1000);
    chk("hiccup_retry", o_state, 1);

    // fault beats enable drop; hiccup then ends in OFF; retained count latches on next fault
    i_ss_done = 1'b1;
    tick();
    i_ss_done = 1'b0;
    i_ocp = 1'b1;
    tick(); tick(); tick();
    i_enable = 1'b0;
    tick();
    i_ocp = 1'b0;
    chk("fault_vs_disable", o_state, 3);
    tick();
    n = 0;
    while (o_state == 3'd4 && n < 1100) begin n++; tick(); end
    chk("hiccup_to_off", int'({o_state, o_fault}), int'({3'd0, 1'b0}));
    i_enable = 1'b1;
    tick();
    i_ocp = 1'b1;
    tick(); tick(); tick(); tick();
    chk("third_fault", o_state, 3);
    tick();
    i_ocp = 1'b0;
    chk("third_latch", int'({o_state, o_latched, o_fault, o_pwm_enable}), int'({3'd5, 1'b1, 1'b1, 1'b0}));

    // persistent OCP from reset: three faults then latch-off, release, re-latch
    do_reset();
    i_enable = 1'b1; i_ocp = 1'b1;
    count_faults_to_latch(f);
    chk("latch_faults", f, 3);
    chk("latch_outs", int'({o_state, o_latched, o_pwm_enable, o_duty}), int'({3'd5, 1'b1, 1'b0, 8'd0}));
    for (int k = 0; k < 5; k++) tick();
    chk("latch_hold", o_state, 5);
    i_enable = 1'b0; i_ocp = 1'b0;
    tick();
    chk("latch_release", int'({o_state, o_latched, o_fault}), int'({3'd0, 1'b0, 1'b0}));
    i_enable = 1'b1; i_ocp = 1'b1;
    count_faults_to_latch(f);
    chk("count_cleared", f, 3);

    // soft-start timeout without done
    do_reset();
    i_enable = 1'b1;
    tick();
    n = 0;
    while (o_state == 3'd1 && n < 5000) begin n++; tick(); end
    chk("ss_timeout_len", n, 4096);
    chk("ss_timeout_fault", int'({o_state, o_fault}), int'({3'd3, 1'b1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
